// File: rtl/afu_port_reset_seq_if.sv
// Port-gasket reset bundle: per-port reset requests and idle status in,
// quiesce, soft-reset, state and drain-error status out.
interface afu_port_reset_seq_if #(
  parameter int PG_NUM_PORTS = 1
);
  logic [PG_NUM_PORTS-1:0]   port_rst_n;
  logic [PG_NUM_PORTS-1:0]   port_idle;
  logic [PG_NUM_PORTS-1:0]   port_quiesce;
  logic [PG_NUM_PORTS-1:0]   port_softreset_n;
  logic [2*PG_NUM_PORTS-1:0] port_state;
  logic [PG_NUM_PORTS-1:0]   drain_timeout_err;

  modport master (
    output port_rst_n,
    output port_idle,
    input  port_quiesce,
    input  port_softreset_n,
    input  port_state,
    input  drain_timeout_err
  );

  modport slave (
    input  port_rst_n,
    input  port_idle,
    output port_quiesce,
    output port_softreset_n,
    output port_state,
    output drain_timeout_err
  );
endinterface

// File: rtl/afu_port_reset_seq.sv
// Per-port soft-reset sequencer: synchronise request, quiesce traffic,
// hold reset for a minimum width, then release ports staggered by index.
module afu_port_reset_seq #(
  parameter int PG_NUM_PORTS      = 1,
  parameter int SYNC_STAGES       = 2,
  parameter int MIN_ASSERT_CYCLES = 16,
  parameter int DRAIN_TIMEOUT     = 1024,
  parameter int STAGGER_CYCLES    = 4
) (
  input logic clk,
  input logic rst_n,
  afu_port_reset_seq_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    QUIESCE = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int HW = $clog2(MIN_ASSERT_CYCLES + 1);
  localparam int TW =
    (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int SMAX = (PG_NUM_PORTS - 1) * STAGGER_CYCLES;
  localparam int SW = (SMAX > 0) ? $clog2(SMAX + 1) : 1;
  localparam bit SKIP_Q = (DRAIN_TIMEOUT == 0);

  localparam logic [HW-1:0] HOLD_INIT = HW'(MIN_ASSERT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST =
    TW'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);

  for (genvar p = 0; p < PG_NUM_PORTS; p++) begin : g_port
    localparam logic [SW-1:0] STAG = SW'(p * STAGGER_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic                   req_n;
    state_t                 state, state_nxt;
    logic [HW-1:0]          hcnt, hcnt_nxt, hcnt_dec;
    logic [TW-1:0]          tmr, tmr_nxt;
    logic [SW-1:0]          scnt, scnt_nxt;
    logic                   q, q_nxt;
    logic                   sr, sr_nxt;
    logic                   err, err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else sync <= {sync[SYNC_STAGES-2:0], bus.port_rst_n[p]};
    end

    assign req_n = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= HOLD;
        hcnt  <= HOLD_INIT;
        tmr   <= '0;
        scnt  <= '0;
        q     <= 1'b0;
        sr    <= 1'b0;
        err   <= 1'b0;
      end else begin
        state <= state_nxt;
        hcnt  <= hcnt_nxt;
        tmr   <= tmr_nxt;
        scnt  <= scnt_nxt;
        q     <= q_nxt;
        sr    <= sr_nxt;
        err   <= err_nxt;
      end
    end

    // Saturating down-count; HOLD exits on the edge it lands on zero.
    assign hcnt_dec = (hcnt != '0) ? hcnt - 1'b1 : '0;

    always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      tmr_nxt   = tmr;
      scnt_nxt  = scnt;
      q_nxt     = q;
      sr_nxt    = sr;
      err_nxt   = err;
      unique case (state)
        RUN: begin
          if (!req_n) begin
            if (SKIP_Q) begin
              state_nxt = HOLD;
              hcnt_nxt  = HOLD_INIT;
              sr_nxt    = 1'b0;
            end else begin
              state_nxt = QUIESCE;
              tmr_nxt   = '0;
              q_nxt     = 1'b1;
            end
          end
        end
        QUIESCE: begin
          if (bus.port_idle[p]) begin
            state_nxt = HOLD;
            hcnt_nxt  = HOLD_INIT;
            q_nxt     = 1'b0;
            sr_nxt    = 1'b0;
          end else if (tmr == TMO_LAST) begin
            state_nxt = HOLD;
            hcnt_nxt  = HOLD_INIT;
            q_nxt     = 1'b0;
            sr_nxt    = 1'b0;
            err_nxt   = 1'b1;
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
        HOLD: begin
          hcnt_nxt = hcnt_dec;
          if (hcnt_dec == '0 && req_n) begin
            state_nxt = RELEASE;
            scnt_nxt  = STAG;
          end
        end
        RELEASE: begin
          // Traffic is already stopped, so a new request skips QUIESCE.
          if (!req_n) begin
            state_nxt = HOLD;
            hcnt_nxt  = HOLD_INIT;
          end else if (scnt == '0) begin
            state_nxt = RUN;
            sr_nxt    = 1'b1;
          end else begin
            scnt_nxt = scnt - 1'b1;
          end
        end
      endcase
    end

    assign bus.port_quiesce[p]          = q;
    assign bus.port_softreset_n[p]      = sr;
    assign bus.drain_timeout_err[p]     = err;
    assign bus.port_state[2*p +: 2]     = state;
  end

endmodule
